// File: rtl/mcycle_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit: MCycleOp
// field layout and FSM state values.
package mcycle_pkg;

    // MCycleOp bit positions
    localparam int OP_KIND_BIT = 1;   // 0 = multiply, 1 = divide
    localparam int OP_SIGN_BIT = 0;   // 0 = unsigned, 1 = signed

    // Full MCycleOp encodings
    localparam logic [1:0] OP_MULU = 2'b00;
    localparam logic [1:0] OP_MULS = 2'b01;
    localparam logic [1:0] OP_DIVU = 2'b10;
    localparam logic [1:0] OP_DIVS = 2'b11;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_FIXUP   = 2'd2;

endpackage

// File: rtl/mcycle_div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder and subtract the divisor when it fits.
// Only built when MCYCLE_DIV_EN is defined.
`ifdef MCYCLE_DIV_EN
module mcycle_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] diff;

    // Trial subtraction; the low WIDTH bits of the difference are exact
    // whenever the subtraction is taken, since the result is < divisor.
    always_comb begin
        rem_shift = {rem_in, dvd_bit};
        q_bit     = (rem_shift >= {1'b0, divisor});
        diff      = rem_shift[WIDTH-1:0] - divisor;
        rem_out   = q_bit ? diff : rem_shift[WIDTH-1:0];
    end

endmodule
`endif

// File: rtl/mcycle_unit.sv
// Multi-cycle multiply/divide unit: iterative shift-add multiply and
// restoring divide on operand magnitudes, with a sign fix-up cycle.
// Fixed latency of WIDTH+1 cycles from acceptance to Done.
// Divide hardware is present only when MCYCLE_DIV_EN is defined; otherwise
// a divide request completes on time with zero results.
module mcycle_unit
    import mcycle_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   res1_q, res1_d;
    logic [WIDTH-1:0]   res2_q, res2_d;

    logic               op_signed, sign1, sign2;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] step_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix1, fix2;

`ifdef MCYCLE_DIV_EN
    logic               rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0]   op1_q, op1_d;
    logic [WIDTH-1:0]   div_rem;
    logic               div_q_bit;

    // prod_q holds {partial remainder, dividend/quotient shift register}
    mcycle_div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_in  (prod_q[2*WIDTH-1:WIDTH]),
        .dvd_bit (prod_q[WIDTH-1]),
        .divisor (mag_b_q),
        .rem_out (div_rem),
        .q_bit   (div_q_bit)
    );
`endif

    // Operand sign extraction and magnitudes (most-negative stays as an
    // unsigned 2^(WIDTH-1) magnitude)
    always_comb begin
        op_signed = MCycleOp[OP_SIGN_BIT];
        sign1     = op_signed & Operand1[WIDTH-1];
        sign2     = op_signed & Operand2[WIDTH-1];
        mag1      = sign1 ? -Operand1 : Operand1;
        mag2      = sign2 ? -Operand2 : Operand2;
    end

    // One iteration of the selected algorithm on prod_q
    always_comb begin
        // prod_q holds {high accumulator, multiplier shift register}
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                  + {1'b0, {WIDTH{prod_q[0]}} & mag_b_q};
        step_next = {mul_sum, prod_q[WIDTH-1:1]};
`ifdef MCYCLE_DIV_EN
        if (is_div_q) begin
            step_next = {div_rem, prod_q[WIDTH-2:0], div_q_bit};
        end
`endif
    end

    // Sign fix-up and special cases applied in the FIXUP cycle
    always_comb begin
        prod_fix = neg_q ? -prod_q : prod_q;
        fix1     = prod_fix[WIDTH-1:0];
        fix2     = prod_fix[2*WIDTH-1:WIDTH];
        if (is_div_q) begin
`ifdef MCYCLE_DIV_EN
            // Most-negative / -1 needs no special case: the magnitude
            // quotient 2^(WIDTH-1) with a positive sign already reads back
            // as most-negative, and the remainder is zero.
            fix1 = neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
            fix2 = rem_neg_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
            if (mag_b_q == '0) begin
                fix1 = '1;
                fix2 = op1_q;
            end
`else
            fix1 = '0;
            fix2 = '0;
`endif
        end
    end

    // FSM sequencing, operand capture and iteration register updates
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        mag_b_d  = mag_b_q;
        prod_d   = prod_q;
        res1_d   = res1_q;
        res2_d   = res2_q;
`ifdef MCYCLE_DIV_EN
        rem_neg_d = rem_neg_q;
        op1_d     = op1_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d  = ST_COMPUTE;
                    cnt_d    = '0;
                    is_div_d = MCycleOp[OP_KIND_BIT];
                    neg_d    = sign1 ^ sign2;
                    mag_b_d  = mag1;
                    prod_d   = {{WIDTH{1'b0}}, mag2};
`ifdef MCYCLE_DIV_EN
                    rem_neg_d = sign1;
                    op1_d     = Operand1;
                    if (MCycleOp[OP_KIND_BIT]) begin
                        mag_b_d = mag2;
                        prod_d  = {{WIDTH{1'b0}}, mag1};
                    end
`endif
                end
            end
            ST_COMPUTE: begin
                prod_d = step_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                state_d = ST_IDLE;
                res1_d  = fix1;
                res2_d  = fix2;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            mag_b_q  <= '0;
            prod_q   <= '0;
            res1_q   <= '0;
            res2_q   <= '0;
`ifdef MCYCLE_DIV_EN
            rem_neg_q <= 1'b0;
            op1_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            mag_b_q  <= mag_b_d;
            prod_q   <= prod_d;
            res1_q   <= res1_d;
            res2_q   <= res2_d;
`ifdef MCYCLE_DIV_EN
            rem_neg_q <= rem_neg_d;
            op1_q     <= op1_d;
`endif
        end
    end

    // Results are shown from the fix-up logic during the Done cycle and
    // from the holding registers afterwards, so they are valid with Done.
    assign Done    = (state_q == ST_FIXUP);
    assign Busy    = ~Reset & ((state_q != ST_IDLE) | Start);
    assign Result1 = Done ? fix1 : res1_q;
    assign Result2 = Done ? fix2 : res2_q;

endmodule

// File: tb/tb_mcycle_unit.sv
// Self-checking bench for mcycle_unit (WIDTH=32) against a timeline and
// arithmetic reference model.
module tb_mcycle_unit;
    import mcycle_pkg::*;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         Reset = 1'b0;
    logic         Start = 1'b0;
    logic [1:0]   MCycleOp = 2'b00;
    logic [W-1:0] Operand1 = '0;
    logic [W-1:0] Operand2 = '0;
    logic [W-1:0] Result1, Result2;
    logic         Busy, Done;

    mcycle_unit #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    bit checks_on = 1'b0;
    int cyc_now = 0;
    int acc_edge = 0;

    // reference model state
    bit           m_in_op = 1'b0;
    int           m_t = 0;
    logic [W-1:0] m_r1 = '0, m_r2 = '0, m_p1 = '0, m_p2 = '0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b,
                                       output logic [W-1:0] r1, output logic [W-1:0] r2);
        logic [2*W-1:0] p;
        longint sa, sb, q, r;
        r1 = '0;
        r2 = '0;
        if (op[1] == 1'b0) begin
            if (op[0]) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = sa * sb;
            end else begin
                p = {32'b0, a} * {32'b0, b};
            end
            r1 = p[W-1:0];
            r2 = p[2*W-1:W];
        end else begin
`ifdef MCYCLE_DIV_EN
            if (b == '0) begin
                r1 = '1;
                r2 = a;
            end else if (op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                r1 = 32'h8000_0000;
                r2 = '0;
            end else begin
                if (op[0]) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                end else begin
                    sa = longint'({32'b0, a});
                    sb = longint'({32'b0, b});
                end
                q  = sa / sb;
                r  = sa % sb;
                r1 = q[W-1:0];
                r2 = r[W-1:0];
            end
`endif
        end
    endfunction

    always @(posedge CLK) cyc_now++;

    // Timeline model: accept in idle, Done WIDTH+1 cycles after the accept edge
    always @(posedge CLK) begin
        if (Reset) begin
            m_in_op = 1'b0;
            m_t = 0;
            m_r1 = '0;
            m_r2 = '0;
        end else if (m_in_op) begin
            if (m_t == W + 1) begin
                m_in_op = 1'b0;
            end else begin
                m_t++;
                if (m_t == W + 1) begin
                    m_r1 = m_p1;
                    m_r2 = m_p2;
                end
            end
        end else if (Start) begin
            m_in_op = 1'b1;
            m_t = 1;
            ref_result(MCycleOp, Operand1, Operand2, m_p1, m_p2);
        end
    end

    // Per-cycle comparison against the model
    always @(negedge CLK) begin
        if (checks_on) begin
            chk("busy", W'(Busy), W'(!Reset && (m_in_op || Start)));
            chk("done", W'(Done), W'(m_in_op && m_t == W + 1));
            chk("result1", Result1, m_r1);
            chk("result2", Result2, m_r2);
        end
    end

    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge CLK);
        #1;
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
        Start = 1'b1;
        @(negedge CLK);
        acc_edge = cyc_now;
        #1;
        Start = 1'b0;
        MCycleOp = 2'($urandom);
        Operand1 = $urandom;
        Operand2 = $urandom;
    endtask

    task automatic wait_done(output int lat);
        int n = 0;
        while (Done !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        lat = (n >= 100) ? -1 : (cyc_now - acc_edge + 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_in_op && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("idle_timeout", W'(m_in_op), W'(0));
    endtask

    task automatic run_lit(input string name, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] e1, input logic [W-1:0] e2);
        logic [W-1:0] p1, p2;
        int lat;
        ref_result(op, a, b, p1, p2);
        chk({name, "_model_r1"}, p1, e1);
        chk({name, "_model_r2"}, p2, e2);
        start_op(op, a, b);
        wait_done(lat);
        chk({name, "_latency"}, W'(lat), W'(33));
        chk({name, "_r1"}, Result1, e1);
        chk({name, "_r2"}, Result2, e2);
        // Start held in the Done cycle must not be accepted
        #1;
        Start = 1'b1;
        @(negedge CLK);
        #1;
        Start = 1'b0;
        wait_idle();
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 20));
            4:       return -W'($urandom_range(1, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int lat;
        int dn;
        #1 Reset = 1'b1;
        repeat (2) @(negedge CLK);
        checks_on = 1'b1;
        chk("reset_busy", W'(Busy), W'(0));
        chk("reset_done", W'(Done), W'(0));
        chk("reset_r1", Result1, '0);
        chk("reset_r2", Result2, '0);
        #1 Reset = 1'b0;

        run_lit("mulu_max", OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);
        run_lit("muls_m3x7", OP_MULS, -32'sd3, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF);
`ifdef MCYCLE_DIV_EN
        run_lit("divs_m7d2", OP_DIVS, -32'sd7, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_lit("divu_100d7", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2);
        run_lit("divu_5d0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
        run_lit("divs_ovf", OP_DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
`else
        run_lit("divs_m7d2", OP_DIVS, -32'sd7, 32'd2, 32'd0, 32'd0);
        run_lit("divu_100d7", OP_DIVU, 32'd100, 32'd7, 32'd0, 32'd0);
`endif

        // Start re-pulsed during COMPUTE with new operands is ignored
        start_op(OP_MULU, 32'd1234, 32'd5678);
        repeat (2) begin
            @(negedge CLK);
            #1;
            Start = 1'b1;
            MCycleOp = OP_DIVS;
            Operand1 = $urandom;
            Operand2 = $urandom;
            @(negedge CLK);
            #1;
            Start = 1'b0;
        end
        wait_done(lat);
        chk("restart_latency", W'(lat), W'(33));
        chk("restart_r1", Result1, 32'd7006652);
        chk("restart_r2", Result2, 32'd0);
        wait_idle();

        // Reset in cycle 10 of a multiply aborts it with no Done
        start_op(OP_MULS, -32'sd5, 32'd9);
        repeat (9) @(negedge CLK);
        #1 Reset = 1'b1;
        @(negedge CLK);
        chk("abort_busy", W'(Busy), W'(0));
        chk("abort_done", W'(Done), W'(0));
        repeat (2) @(negedge CLK);
        #1 Reset = 1'b0;
        dn = 0;
        repeat (40) begin
            @(negedge CLK);
            if (Done === 1'b1) dn++;
        end
        chk("abort_no_done", W'(dn), W'(0));
        run_lit("mul_6x7", OP_MULU, 32'd6, 32'd7, 32'd42, 32'd0);

        // Randomized operations, with stray Start pulses during COMPUTE
        for (int i = 0; i < 40; i++) begin
            start_op(2'($urandom_range(0, 3)), pick(), pick());
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge CLK);
                    #1;
                    Start = 1'b1;
                    MCycleOp = 2'($urandom);
                    Operand1 = $urandom;
                    Operand2 = $urandom;
                    @(negedge CLK);
                    #1;
                    Start = 1'b0;
                end
            end
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        @(negedge CLK);
        checks_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
